// File: rtl/seg7_counter_display.sv
// seg7_counter_display: up/down hex or BCD counter, stepped by KEY[1] or a tick divider,
// shown on active-low 7-segment displays.
module seg7_counter_display #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic                MAX10_CLK1_50,
    input  logic [1:0]          KEY,
    input  logic [9:0]          SW,
    output logic [7*DIGITS-1:0] HEX,
    output logic [1:0]          LEDR
);
    localparam int TW = $clog2(TICK_DIV);
    logic clk, rst_n;
    logic [1:0] key_sy;
    logic key_prev;
    logic [3:0] sw_m, sw_s;
    logic dec_prev;
    logic [TW-1:0] tcnt;
    logic [DIGITS-1:0][3:0] dig, nxt, ld;
    logic [7*DIGITS-1:0] hex_n, hex_r;
    logic [3:0] lim;
    logic wrp, wrap, tick, step, adv, mode_chg, run, down, dec, load;
    logic unused_sw;
    assign clk = MAX10_CLK1_50;
    assign rst_n = KEY[0];
    assign unused_sw = ^SW[5:4];
    assign {run, down, dec, load} = sw_s;
    // falling edge of the synchronised button; reset clears both flops so a held key never steps
    assign step = key_prev & ~key_sy[1];
    assign tick = run && tcnt == TW'(TICK_DIV - 1);
    assign adv = tick | step;
    assign mode_chg = dec != dec_prev;
    assign lim = dec ? 4'd9 : 4'd15;
    assign HEX = hex_r;
    assign LEDR = {run, wrp};

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        ld = '0;
        ld[0] = (dec && SW[3:0] > 4'd9) ? 4'd9 : SW[3:0];
    end

    // digit-serial ripple: the same carry/borrow chain serves hex (limit 15) and BCD (limit 9)
    always_comb begin : ripple
        logic c;
        c = 1'b1;
        nxt = dig;
        for (int i = 0; i < DIGITS; i++) begin
            nxt[i] = !c ? dig[i] : down ? (dig[i] == 4'd0 ? lim : dig[i] - 4'd1)
                                        : (dig[i] >= lim ? 4'd0 : dig[i] + 4'd1);
            c = c & (down ? dig[i] == 4'd0 : dig[i] >= lim);
        end
        wrap = c;
    end

    always_comb begin
        hex_n = '0;
        for (int i = 0; i < DIGITS; i++) hex_n[7*i +: 7] = seg(dig[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sy   <= '0;
            key_prev <= 1'b0;
            sw_m     <= '0;
            sw_s     <= '0;
            dec_prev <= 1'b0;
            tcnt     <= '0;
            dig      <= '0;
            wrp      <= 1'b0;
            hex_r    <= {DIGITS{7'b1000000}};
        end else begin
            key_sy   <= {key_sy[0], KEY[1]};
            key_prev <= key_sy[1];
            sw_m     <= SW[9:6];
            sw_s     <= sw_m;
            dec_prev <= dec;
            tcnt     <= !run ? '0 : tick ? '0 : tcnt + 1'b1;
            if (mode_chg) dig <= '0;
            else if (load) dig <= ld;
            else if (adv) dig <= nxt;
            if (adv && wrap && !mode_chg && !load) wrp <= ~wrp;
            hex_r    <= hex_n;
        end
    end
endmodule

// File: tb/tb_seg7_counter_display.sv
// tb_seg7_counter_display: table vectors, corner sequences and a randomized run against
// an integer model of the counter (DIGITS=2, TICK_DIV=4).
module tb_seg7_counter_display;
    logic clk = 1'b0;
    logic [1:0] key = 2'b11;
    logic [9:0] sw = '0;
    logic [13:0] hex;
    logic [1:0] ledr;
    int n_pass = 0, n_tot = 0;
    int v, mx;
    bit dec, wl, w;
    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef struct {
        bit dec;
        bit down;
        logic [3:0] ld;
        int n;
        int expv;
        bit expw;
    } vec_t;
    vec_t vecs [9];

    seg7_counter_display #(.DIGITS(2), .TICK_DIV(4)) dut (
        .MAX10_CLK1_50(clk),
        .KEY(key),
        .SW(sw),
        .HEX(hex),
        .LEDR(ledr)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] model_hex(input int val, input bit d);
        int base = d ? 10 : 16;
        return {glyph[(val / base) % 16], glyph[val % base]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_st(input string nm, input int val, input bit d, input bit run, input bit wr);
        chk({nm, " hex"}, 16'(hex), 16'(model_hex(val, d)));
        chk({nm, " led"}, 16'(ledr), 16'({run, wr}));
    endtask

    task automatic press();
        key[1] = 1'b0;
        cyc(4);
        key[1] = 1'b1;
        cyc(4);
    endtask

    task automatic do_reset(input bit d);
        key = 2'b10;
        sw = '0;
        sw[7] = d;
        cyc(2);
        key = 2'b11;
        cyc(4);
    endtask

    task automatic load(input logic [3:0] val);
        sw[3:0] = val;
        sw[6] = 1'b1;
        cyc(4);
        sw[6] = 1'b0;
        cyc(4);
    endtask

    initial begin
        vecs[0] = '{0, 0, 4'd0, 4, 4, 0};
        vecs[1] = '{1, 0, 4'd9, 1, 10, 0};
        vecs[2] = '{1, 1, 4'd0, 1, 99, 1};
        vecs[3] = '{0, 1, 4'd0, 1, 255, 1};
        vecs[4] = '{0, 0, 4'd12, 5, 17, 0};
        vecs[5] = '{1, 0, 4'd12, 0, 9, 0};
        vecs[6] = '{0, 0, 4'd15, 1, 16, 0};
        vecs[7] = '{1, 1, 4'd3, 4, 99, 1};
        vecs[8] = '{1, 0, 4'd9, 3, 12, 0};

        // asynchronous reset before any clock edge
        #2 key = 2'b10;
        #1 chk_st("reset", 0, 0, 0, 0);
        cyc(2);
        key = 2'b11;
        cyc(4);

        for (int i = 0; i < 9; i++) begin
            do_reset(vecs[i].dec);
            load(vecs[i].ld);
            sw[8] = vecs[i].down;
            cyc(4);
            for (int k = 0; k < vecs[i].n; k++) press();
            chk_st($sformatf("vec%0d", i), vecs[i].expv, vecs[i].dec, 0, vecs[i].expw);
        end

        // decimal wrap both ways toggles the wrap LED each time
        do_reset(1);
        sw[8] = 1'b1; cyc(3); press();
        chk_st("dec 00-down", 99, 1, 0, 1);
        sw[8] = 1'b0; cyc(3); press();
        chk_st("dec 99-up", 0, 1, 0, 0);
        sw[8] = 1'b1; cyc(3); press();
        chk_st("dec 00-down2", 99, 1, 0, 1);

        // load held with steps: count stays at the load value
        do_reset(0);
        sw[3:0] = 4'hC;
        sw[6] = 1'b1;
        cyc(3);
        press();
        press();
        chk_st("load+steps", 12, 0, 0, 0);
        sw[6] = 1'b0;
        cyc(4);

        // auto-count: 40 run cycles after sync -> 10 ticks
        do_reset(0);
        sw[9] = 1'b1;
        cyc(20);
        chk("run led", 16'(ledr), 16'(2'b10));
        cyc(22);
        sw[9] = 1'b0;
        cyc(4);
        chk_st("tick x10", 10, 0, 0, 0);

        // 37 in decimal, then switch to hex clears within 4 cycles
        do_reset(1);
        load(4'd7);
        for (int k = 0; k < 30; k++) press();
        chk_st("dec 37", 37, 1, 0, 0);
        sw[7] = 1'b0;
        cyc(4);
        chk_st("mode clear", 0, 0, 0, 0);

        // reset mid-run at 5A with KEY[1] held low through release
        do_reset(0);
        load(4'hA);
        for (int k = 0; k < 80; k++) press();
        sw[9] = 1'b1;
        cyc(3);
        chk_st("hex 5A", 8'h5A, 0, 1, 0);
        #2 key = 2'b00;
        #1 chk_st("async reset", 0, 0, 0, 0);
        sw[9] = 1'b0;
        cyc(3);
        key = 2'b01;
        cyc(6);
        key = 2'b11;
        cyc(6);
        chk_st("held key", 0, 0, 0, 0);

        // randomized operations against the integer model
        do_reset(0);
        v = 0; dec = 0; wl = 0;
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                sw[8] = 1'($urandom_range(0, 1));
                cyc(2);
                press();
                mx = dec ? 99 : 255;
                w = sw[8] ? v == 0 : v == mx;
                v = sw[8] ? (v + mx) % (mx + 1) : (v + 1) % (mx + 1);
                if (w) wl = ~wl;
            end else if (r <= 7) begin
                logic [3:0] val;
                val = 4'($urandom_range(0, 15));
                sw[3:0] = val;
                sw[6] = 1'b1;
                cyc(3);
                if ($urandom_range(0, 1) == 1) press();
                sw[6] = 1'b0;
                cyc(4);
                v = (dec && val > 9) ? 9 : int'(val);
            end else if (r == 8) begin
                dec = ~dec;
                sw[7] = dec;
                cyc(5);
                v = 0;
            end else begin
                sw[8] = ~sw[8];
                cyc(3);
            end
            chk_st($sformatf("rand%0d", i), v, dec, 0, wl);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/seg7_counter_display.md
SEG7_COUNTER_DISPLAY -- requirements
Module: seg7_counter_display

Interface
REQ-001 Parameter DIGITS, default 2: number of counter digits and 7-segment displays driven, legal range 1..6.
REQ-002 Parameter TICK_DIV, default 50000000: clock cycles per auto-count tick, legal range >= 2.
REQ-003 MAX10_CLK1_50  input  1  system clock; all state changes on its rising edge.
REQ-004 KEY  input  2  KEY[0] is the reset: asynchronous, active-low; KEY[1] is the manual step push-button, active-low, asynchronous to the clock.
REQ-005 SW  input  10  SW[9] run, SW[8] direction (1 = down), SW[7] decimal mode (1 = BCD), SW[6] load, SW[3:0] load value; SW[5:4] unused.
REQ-006 HEX  output  7*DIGITS  segment drive, digit d on bits [7d+6:7d], bit 0 = segment a through bit 6 = segment g, active-low (0 = lit).
REQ-007 LEDR  output  2  LEDR[0] wrap indicator, LEDR[1] run indicator.

Function
REQ-008 The count SHALL be held as DIGITS 4-bit digits, digit 0 least significant.
REQ-009 KEY[1] SHALL pass through a 2-flop synchroniser; a synchronised 1->0 transition SHALL produce exactly one single-cycle step request.
REQ-010 A tick counter SHALL count 0..TICK_DIV-1 while SW[9]=1 and emit a one-cycle tick on reaching TICK_DIV-1; while SW[9]=0 it SHALL hold at 0.
REQ-011 An advance SHALL occur on a cycle with a tick or a step request; tick and step in the same cycle SHALL produce one advance only.
REQ-012 Hex mode: the count SHALL behave as a 4*DIGITS-bit binary counter, wrapping max -> 0 (up) and 0 -> max (down), max = 16^DIGITS-1.
REQ-013 Decimal mode: each digit SHALL range 0..9 with ripple carry/borrow between digits, wrapping 10^DIGITS-1 -> 0 (up) and 0 -> 10^DIGITS-1 (down).
REQ-014 A change of SW[7] (synchronised, detected on any edge) SHALL clear all digits to 0 on the following cycle, taking priority over any advance.
REQ-015 While SW[6]=1 the count SHALL be loaded every cycle: digit 0 = SW[3:0] (clamped to 9 in decimal mode), all other digits = 0; advances are ignored.
REQ-016 Priority per cycle, highest first: reset, mode-change clear, load, advance, hold.
REQ-017 SW[9:6] SHALL be sampled through a 2-flop synchroniser before use.
REQ-018 LEDR[0] SHALL toggle on every cycle in which an advance wraps the count; loads and clears SHALL not toggle it.
REQ-019 LEDR[1] SHALL equal synchronised SW[9].
REQ-020 HEX SHALL be registered, updated one cycle after the count changes, decoding each digit 0-F with the standard glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bit 6 down to bit 0).
REQ-021 Direction changes SHALL take effect at the next advance with no loss or duplication of the current count.

Reset
REQ-022 KEY[0]=0 SHALL immediately clear all digits, the tick counter, synchronisers and edge detectors, set LEDR to 00 and every HEX digit to 1000000, regardless of the clock.
REQ-023 Reset asserted mid-count SHALL abort any pending advance; after release the first advance SHALL start from 0 with a full TICK_DIV period.
REQ-024 A KEY[1] held low through reset release SHALL NOT produce a step.

Verification
REQ-025 DIGITS=2, hex, up, four KEY[1] presses -> count 04, HEX[6:0]=0011001, HEX[13:7]=1000000.
REQ-026 DIGITS=2, decimal, count 99, one up step -> count 00, LEDR[0] toggles; one down step -> 99, LEDR[0] toggles again.
REQ-027 DIGITS=2, hex, TICK_DIV=4, SW[9]=1 for 40 cycles after sync -> exactly 10 advances, count 0A, HEX[6:0]=0001000.
REQ-028 SW[6]=1, SW[3:0]=C in decimal -> count 09; same in hex -> count 0C; steps during load leave the count unchanged.
REQ-029 Count 37 in decimal, toggle SW[7] to hex -> count 00 within 4 cycles, no LEDR[0] toggle.
REQ-030 KEY[0] pulsed low mid-run with count 5A -> outputs reset asynchronously; KEY[1] held low across release -> count stays 00.
